// File: rtl/fib_pkg.sv
// Shared definitions for the Fibonacci generator and checker: state encoding,
// default term width and the two seed terms of the sequence.
package fib_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SEED  = 3'd1,
        ST_CHECK = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERROR = 3'd4
    } fib_chk_state_t;

    localparam int FIB_WIDTH = 17;
    localparam int FIB_SEED0 = 0;
    localparam int FIB_SEED1 = 1;

endpackage

// File: rtl/fibonacci_checker.sv
// Checks a term stream against the Fibonacci recurrence from 0, 1.
// Latency: one edge, because all outputs are registered.
// Backpressure: none. Each in_valid cycle is consumed, and idle gaps of any length are legal.
module fibonacci_checker
    import fib_pkg::*;
#(
    parameter int WIDTH   = FIB_WIDTH,
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               in_valid,
    input  logic [WIDTH-1:0]   in_data,
    output logic [COUNT_W-1:0] count,
    output logic               error,
    output logic [COUNT_W-1:0] err_index,
    output logic [WIDTH-1:0]   expected,
    output logic               done
);

    fib_chk_state_t     state, state_nx;
    logic [WIDTH-1:0]   a, a_nx;
    logic [WIDTH-1:0]   b, b_nx;
    logic [COUNT_W-1:0] count_nx, count_inc;
    logic [COUNT_W-1:0] err_index_nx;
    logic [WIDTH-1:0]   expected_nx;
    logic [WIDTH-1:0]   sum;
    logic               next_ovf;

    // a + b cannot overflow in CHECK, because DONE is entered one term before that happens.
    assign sum       = a + b;
    assign next_ovf  = ({1'b0, b} + {1'b0, in_data}) > {1'b0, {WIDTH{1'b1}}};
    assign count_inc = (count == {COUNT_W{1'b1}}) ? count : count + 1'b1;

    always_comb begin
        state_nx     = state;
        a_nx         = a;
        b_nx         = b;
        count_nx     = count;
        err_index_nx = err_index;
        expected_nx  = expected;
        if (clear) begin
            state_nx     = ST_IDLE;
            a_nx         = '0;
            b_nx         = '0;
            count_nx     = '0;
            err_index_nx = '0;
            expected_nx  = '0;
        end else if (in_valid) begin
            case (state)
                ST_IDLE: begin
                    if (in_data == WIDTH'(FIB_SEED0)) begin
                        state_nx = ST_SEED;
                        b_nx     = WIDTH'(FIB_SEED0);
                        count_nx = COUNT_W'(1);
                    end else begin
                        state_nx     = ST_ERROR;
                        err_index_nx = COUNT_W'(0);
                        expected_nx  = WIDTH'(FIB_SEED0);
                    end
                end
                ST_SEED: begin
                    if (in_data == WIDTH'(FIB_SEED1)) begin
                        state_nx = ST_CHECK;
                        a_nx     = WIDTH'(FIB_SEED0);
                        b_nx     = WIDTH'(FIB_SEED1);
                        count_nx = COUNT_W'(2);
                    end else begin
                        state_nx     = ST_ERROR;
                        err_index_nx = COUNT_W'(1);
                        expected_nx  = WIDTH'(FIB_SEED1);
                    end
                end
                ST_CHECK: begin
                    if (in_data == sum) begin
                        a_nx     = b;
                        b_nx     = in_data;
                        count_nx = count_inc;
                        if (next_ovf)
                            state_nx = ST_DONE;
                    end else begin
                        state_nx     = ST_ERROR;
                        err_index_nx = count;
                        expected_nx  = sum;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            a         <= '0;
            b         <= '0;
            count     <= '0;
            err_index <= '0;
            expected  <= '0;
            error     <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nx;
            a         <= a_nx;
            b         <= b_nx;
            count     <= count_nx;
            err_index <= err_index_nx;
            expected  <= expected_nx;
            error     <= (state_nx == ST_ERROR);
            done      <= (state_nx == ST_DONE);
        end
    end

endmodule

// File: doc/fibonacci_checker.md
# fibonacci_checker

Consumer-side counterpart to the `fibonacci` generator. It samples a stream of terms, checks each term against the Fibonacci recurrence starting from 0, 1, and reports the number of correct terms, the first mismatch, and the point where the sequence leaves the data width. It sits on the generator's output, or any `WIDTH`-bit term source, as a self-checking monitor that is synthesizable and usable in benches.

## Interface
Parameters:
- `WIDTH`, default 17: term width; matches the generator output.
- `COUNT_W`, default 8: width of the term counter and the error index.

Ports:
- `clk`, in, 1: single clock; all logic is rising-edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `clear`, in, 1: synchronous restart to IDLE; has priority over `in_valid`.
- `in_valid`, in, 1: `in_data` carries a term this cycle.
- `in_data`, in, `WIDTH`: term value.
- `count`, out, `COUNT_W`: number of terms accepted as correct.
- `error`, out, 1: sticky mismatch flag.
- `err_index`, out, `COUNT_W`: zero-based index of the first bad term.
- `expected`, out, `WIDTH`: value the bad term should have had.
- `done`, out, 1: next Fibonacci term exceeds `WIDTH` bits; checking complete.

## Operation
- State registers:
  - `a`, `b`: previous two terms, each `WIDTH` bits.
  - `state`: one of IDLE, SEED, CHECK, DONE, ERROR.
- IDLE, on `in_valid`:
  - If `in_data==0`: go to SEED, `b<=0`, `count<=1`.
  - Otherwise: go to ERROR, `err_index<=0`, `expected<=0`.
- SEED, on `in_valid`:
  - If `in_data==1`: go to CHECK, `a<=0`, `b<=1`, `count<=2`.
  - Otherwise: go to ERROR, `err_index<=1`, `expected<=1`.
- CHECK, on `in_valid`:
  - Expected term is `sum = a + b`, computed `WIDTH+1` bits wide. Overflow of this sum is impossible here, because overflow is caught one term earlier (see next bullet).
  - On match: `a<=b`, `b<=in_data`, `count++`. If `b + in_data` (`WIDTH+1` bits) has its MSB set, go to DONE.
  - On mismatch: go to ERROR, `err_index<=count`, `expected<=sum[WIDTH-1:0]`. `count` is not incremented.
- DONE and ERROR are terminal. `in_valid` is ignored there and all outputs hold until `clear` or `reset`.
- With no `in_valid` in any state, nothing changes. Gaps between terms of any length are legal.
- `count` saturates at `2^COUNT_W-1` and does not wrap.
- `clear` in any state: IDLE, with `count`, `error`, `err_index`, `expected`, `done`, `a`, `b` all set to 0. `in_valid` in the same cycle is ignored.
- Output decode: `error` = (state==ERROR), `done` = (state==DONE), both registered.
- For `WIDTH=17`:
  - Terms F0..F26 (0 … 121393) are accepted.
  - DONE is entered on the edge that accepts 121393, since 75025+121393 = 196418 > 131071. `count` is 27 at that point.

## Timing
- All outputs are registered and reflect a term sampled at edge N from edge N onward; the latency is one edge.
- `reset` asserted (low), asynchronously and regardless of `clk`: state IDLE; `count`, `err_index`, `expected`, `a`, `b` all 0; `error` 0, `done` 0.
- Deassertion of `reset` is synchronized externally. The first term can be sampled on the first edge with `reset` high.
- `reset` mid-run behaves exactly like power-on. No partial state survives.
- A term is checked only on an edge where `in_valid` is 1. `in_data` is don't-care otherwise.
- `clear` and `reset` are never required together. If both are active, `reset` wins.

## Structure
- Shared package `fib_pkg` holds:
  - the state enum `fib_chk_state_t` (IDLE, SEED, CHECK, DONE, ERROR);
  - `FIB_WIDTH = 17`, used as the default for both generator and checker;
  - localparams for the seed terms 0 and 1.
- No sub-module. The single adder and compare sit in one always_ff FSM with combinational next-term logic; splitting them adds ports with no reuse.

## Test plan
- Clean prefix: feed 0,1,1,2,3,5,8 with `in_valid` every cycle → `count`=7, `error`=0, `done`=0.
- Gapped stream: same terms with 0–3 idle cycles between them → identical result; `count` never changes on idle cycles.
- Mid-run corruption: feed 0,1,1,2,4 → `error`=1 one edge after the 4, `err_index`=4, `expected`=3, `count`=4. Further valid terms change nothing.
- Bad seed: first term 1 → `error`=1, `err_index`=0, `expected`=0, `count`=0.
- Full run at `WIDTH=17`: feed F0..F26 → `done`=1 after 121393, `count`=27. Then feed 196418 truncated (65346) → ignored, outputs unchanged.
- Restart:
  - `clear` with `in_valid`=1 and `in_data`=5 while in CHECK → IDLE, all outputs 0. A following 0,1,1 then gives `count`=3.
  - Async `reset` pulse between edges mid-run → outputs go to 0 immediately, without waiting for a clock edge.
